// File: rtl/posit_err_monitor_if.sv
// Stream and statistics bundle for posit_err_monitor.
// nar_err_cnt exists only when POSIT_ERR_NAR_EN is defined.
interface posit_err_monitor_if #(
    parameter int N     = 8,
    parameter int CNT_W = 17
);
    logic               start;
    logic [CNT_W-1:0]   num_vec;
    logic               in_valid;
    logic [N-1:0]       dut_out;
    logic [N-1:0]       ref_out;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   vec_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W+N-1:0] sum_diff;
    logic [N-1:0]       max_diff;
    logic [CNT_W-1:0]   max_idx;
    logic               first_err_vld;
    logic [CNT_W-1:0]   first_err_idx;
`ifdef POSIT_ERR_NAR_EN
    logic [CNT_W-1:0]   nar_err_cnt;
`endif

    modport master (
        output start, num_vec, in_valid, dut_out, ref_out,
`ifdef POSIT_ERR_NAR_EN
        input  nar_err_cnt,
`endif
        input  busy, done, vec_cnt, err_cnt, sum_diff,
        input  max_diff, max_idx, first_err_vld, first_err_idx
    );

    modport slave (
        input  start, num_vec, in_valid, dut_out, ref_out,
`ifdef POSIT_ERR_NAR_EN
        output nar_err_cnt,
`endif
        output busy, done, vec_cnt, err_cnt, sum_diff,
        output max_diff, max_idx, first_err_vld, first_err_idx
    );
endinterface

// File: rtl/posit_err_monitor.sv
// Accumulates |dut - ref| error statistics over a run of num_vec posit results.
// Define POSIT_ERR_NAR_EN to treat NaR specially and expose nar_err_cnt.
module posit_err_monitor #(
    parameter int N     = 8,
    parameter int CNT_W = 17
) (
    input logic               clk,
    input logic               rst,
    posit_err_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               take_start;
    logic               accept;
    logic [CNT_W-1:0]   num_q;
    logic [N-1:0]       diff;

    logic [CNT_W-1:0]   vec_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W+N-1:0] sum_diff;
    logic [N-1:0]       max_diff;
    logic [CNT_W-1:0]   max_idx;
    logic               first_err_vld;
    logic [CNT_W-1:0]   first_err_idx;

`ifdef POSIT_ERR_NAR_EN
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
    logic               nar_one;
    logic [CNT_W-1:0]   nar_err_cnt;

    assign bus.nar_err_cnt = nar_err_cnt;
`endif

    always_comb begin
        if (bus.ref_out > bus.dut_out)
            diff = bus.ref_out - bus.dut_out;
        else
            diff = bus.dut_out - bus.ref_out;
`ifdef POSIT_ERR_NAR_EN
        nar_one = 1'b0;
        // A lone NaR is a hard error: pin it to the worst possible distance
        if ((bus.dut_out == NAR) && (bus.ref_out == NAR)) begin
            diff = '0;
        end else if ((bus.dut_out == NAR) || (bus.ref_out == NAR)) begin
            diff    = '1;
            nar_one = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        take_start = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    take_start = 1'b1;
                    state_nx   = (bus.num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (vec_cnt == (num_q - CNT_W'(1)))
                        state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q         <= '0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            sum_diff      <= '0;
            max_diff      <= '0;
            max_idx       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
`ifdef POSIT_ERR_NAR_EN
            nar_err_cnt   <= '0;
`endif
        end else if (take_start) begin
            num_q         <= bus.num_vec;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            sum_diff      <= '0;
            max_diff      <= '0;
            max_idx       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
`ifdef POSIT_ERR_NAR_EN
            nar_err_cnt   <= '0;
`endif
        end else if (accept) begin
            vec_cnt  <= vec_cnt + CNT_W'(1);
            sum_diff <= sum_diff + {{CNT_W{1'b0}}, diff};
            if (diff != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= vec_cnt;
                end
            end
            // Strict compare so ties keep the earliest index
            if (diff > max_diff) begin
                max_diff <= diff;
                max_idx  <= vec_cnt;
            end
`ifdef POSIT_ERR_NAR_EN
            if (nar_one)
                nar_err_cnt <= nar_err_cnt + CNT_W'(1);
`endif
        end
    end

    assign bus.busy          = (state == RUN);
    assign bus.done          = (state == DONE);
    assign bus.vec_cnt       = vec_cnt;
    assign bus.err_cnt       = err_cnt;
    assign bus.sum_diff      = sum_diff;
    assign bus.max_diff      = max_diff;
    assign bus.max_idx       = max_idx;
    assign bus.first_err_vld = first_err_vld;
    assign bus.first_err_idx = first_err_idx;
endmodule

// File: tb/tb_posit_err_monitor.sv
// Scoreboard bench for posit_err_monitor: driver pushes expected run
// statistics, a done-edge monitor pops and compares them.
module tb_posit_err_monitor;
    localparam int N  = 8;
    localparam int CW = 17;

    typedef struct {
        int vec;
        int err;
        int sum;
        int maxd;
        int maxi;
        int fvld;
        int fidx;
        int nar;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    posit_err_monitor_if #(.N(N), .CNT_W(CW)) bus ();
    posit_err_monitor #(.N(N), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   dv [64];
    int   rv [64];
    int   gap[64];
    exp_t sb[$];
    exp_t me;
    bit   prev_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pdiff(input int d, input int r);
        int df;
        df = (d > r) ? d - r : r - d;
`ifdef POSIT_ERR_NAR_EN
        if (d == (1 << (N-1)) && r == (1 << (N-1)))
            df = 0;
        else if (d == (1 << (N-1)) || r == (1 << (N-1)))
            df = (1 << N) - 1;
`endif
        return df;
    endfunction

    function automatic exp_t model(input int nv);
        exp_t e;
        int   df;
        e = '{default: 0};
        for (int i = 0; i < nv; i++) begin
            df    = pdiff(dv[i], rv[i]);
            e.vec = e.vec + 1;
            e.sum = e.sum + df;
            if (df != 0) begin
                e.err = e.err + 1;
                if (e.fvld == 0) begin
                    e.fvld = 1;
                    e.fidx = i;
                end
            end
            if (df > e.maxd) begin
                e.maxd = df;
                e.maxi = i;
            end
            if (df == (1 << N) - 1 && (dv[i] == (1 << (N-1))) != (rv[i] == (1 << (N-1))))
                e.nar = e.nar + 1;
        end
        return e;
    endfunction

    task automatic check_stats(input string tag, input exp_t e);
        chk({tag, ".vec_cnt"},  64'(bus.vec_cnt),       64'(e.vec));
        chk({tag, ".err_cnt"},  64'(bus.err_cnt),       64'(e.err));
        chk({tag, ".sum_diff"}, 64'(bus.sum_diff),      64'(e.sum));
        chk({tag, ".max_diff"}, 64'(bus.max_diff),      64'(e.maxd));
        chk({tag, ".max_idx"},  64'(bus.max_idx),       64'(e.maxi));
        chk({tag, ".ferr_vld"}, 64'(bus.first_err_vld), 64'(e.fvld));
        chk({tag, ".ferr_idx"}, 64'(bus.first_err_idx), 64'(e.fidx));
`ifdef POSIT_ERR_NAR_EN
        chk({tag, ".nar_cnt"},  64'(bus.nar_err_cnt),   64'(e.nar));
`endif
    endtask

    task automatic zero_check(input string tag);
        exp_t z;
        z = '{default: 0};
        chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
        chk({tag, ".done"}, 64'(bus.done), 64'd0);
        check_stats(tag, z);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done && !prev_done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: done rose with no expectation");
                end else begin
                    me = sb.pop_front();
                    check_stats("run", me);
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int nv, input bit nar);
        for (int i = 0; i < nv; i++) begin
            dv[i] = $urandom_range(0, 255);
            case ($urandom % 3)
                0:       rv[i] = dv[i];
                1:       rv[i] = (dv[i] + $urandom_range(0, 6)) & 255;
                default: rv[i] = $urandom_range(0, 255);
            endcase
            if (nar && ($urandom % 4 == 0)) dv[i] = 128;
            if (nar && ($urandom % 4 == 0)) rv[i] = 128;
            gap[i] = $urandom_range(0, 2);
        end
    endtask

    task automatic run(input int nv, input bit mid_start);
        exp_t e;
        e = model(nv);
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.num_vec  = CW'(nv);
        bus.in_valid = 1'b1;
        bus.dut_out  = N'($urandom);
        bus.ref_out  = N'($urandom);
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (nv == 0) begin
            chk("zero.done", 64'(bus.done), 64'd1);
            chk("zero.busy", 64'(bus.busy), 64'd0);
        end
        for (int i = 0; i < nv; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                bus.in_valid = 1'b0;
                bus.start    = mid_start;
                bus.num_vec  = CW'($urandom_range(1, 9));
                bus.dut_out  = N'($urandom);
                step();
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.dut_out  = N'(dv[i]);
            bus.ref_out  = N'(rv[i]);
            if (i == nv - 1) begin
                chk("pre_last.busy", 64'(bus.busy), 64'd1);
                chk("pre_last.done", 64'(bus.done), 64'd0);
            end
            step();
            if (i == nv - 1) begin
                chk("last.busy", 64'(bus.busy), 64'd0);
                chk("last.done", 64'(bus.done), 64'd1);
            end
        end
        bus.in_valid = 1'b0;
        step();
        for (int k = 0; k < 4 && sb.size() != 0; k++) step();
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: %0d runs pending, 0 required", sb.size());
            sb.delete();
        end
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'($urandom);
            bus.dut_out  = N'($urandom);
            bus.ref_out  = N'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        check_stats("frozen", e);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.num_vec  = '0;
        bus.in_valid = 1'b0;
        bus.dut_out  = '0;
        bus.ref_out  = '0;
        #12;
        zero_check("reset");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            dv[i] = $urandom_range(0, 255);
            rv[i] = dv[i];
            gap[i] = 0;
        end
        run(4, 1'b0);

        dv[0] = 'h41; rv[0] = 'h40;
        dv[1] = 'h0C; rv[1] = 'h10;
        dv[2] = 'h20; rv[2] = 'h20;
        for (int i = 0; i < 3; i++) gap[i] = 0;
        run(3, 1'b0);

        pulse_rst();
        run(0, 1'b0);

        fill(2, 1'b0);
        gap[0] = 0;
        gap[1] = 2;
        run(2, 1'b1);

        bus.start   = 1'b1;
        bus.num_vec = CW'(5);
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.dut_out  = N'(3);
        bus.ref_out  = N'(9);
        step();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        zero_check("abort");
        step();
        rst = 1'b0;
        step();
        zero_check("post_abort");

        for (int r = 0; r < 20; r++) begin
            int nv;
            nv = $urandom_range(1, 40);
            fill(nv, 1'b0);
            run(nv, 1'($urandom));
        end

`ifdef POSIT_ERR_NAR_EN
        dv[0] = 'h80; rv[0] = 'h80;
        dv[1] = 'h80; rv[1] = 'h40;
        gap[0] = 0;
        gap[1] = 0;
        run(2, 1'b0);
        for (int r = 0; r < 6; r++) begin
            int nv;
            nv = $urandom_range(1, 30);
            fill(nv, 1'b1);
            run(nv, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
